hbm_axi_mem_bridge: RTL and testbench

//  Converts single-beat core memory requests (valid/ready) into AXI4 single-beat transactions
//  on the S00_AXI slave port of hbm_interface. One transaction is outstanding at a time.

---
 rtl/hbm_bridge_pkg.sv | 27 ++
 rtl/hbm_axi_mem_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_hbm_axi_mem_bridge.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_bridge_pkg.sv
// Shared FSM encoding and AXI4 constants for the core-to-HBM AXI bridge.
package hbm_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WAIT_B,
      RD,
      WAIT_R,
      RESP
   } state_t;

   localparam logic [1:0] BURST_INCR           = 2'b01;
   localparam logic [3:0] CACHE_MODIFIABLE_BUF = 4'b0011;
   localparam logic [1:0] RESP_OKAY            = 2'b00;

   // AxSIZE encoding for a full-width beat: log2 of the bus width in bytes.
   function automatic logic [2:0] axi_size(input int unsigned data_w);
      logic [2:0] size;
      size = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if ((32'd1 << i) == data_w / 8) size = i[2:0];
      end
      return size;
   endfunction

endpackage

// File: rtl/hbm_axi_mem_bridge.sv
// Single-outstanding bridge from core valid/ready requests to AXI4 single-beat
// transactions on hbm_interface S00_AXI, with a sticky hang watchdog.
module hbm_axi_mem_bridge
   import hbm_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W      = 33,
   parameter int unsigned DATA_W      = 256,
   parameter int unsigned ID_W        = 6,
   parameter logic [ID_W-1:0] AXI_ID  = '0,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                  clk,
   input  logic                  uncore_reset,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  hang_o,

   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic [ID_W-1:0]       m_axi_awid,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awlock,
   output logic [3:0]            m_axi_awcache,
   output logic [2:0]            m_axi_awprot,
   output logic [3:0]            m_axi_awqos,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,

   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,

   input  logic [ID_W-1:0]       m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,

   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic [ID_W-1:0]       m_axi_arid,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic [3:0]            m_axi_arqos,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,

   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [ID_W-1:0]       m_axi_rid,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int unsigned     WD_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [WD_W-1:0]     wd_cnt;
   logic                busy;

   // Single outstanding transaction, so response IDs carry no information.
   logic unused_ids;
   assign unused_ids = ^{m_axi_bid, m_axi_rid};

   assign busy = (state == WR) || (state == WAIT_B) || (state == RD) || (state == WAIT_R);

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awid    = AXI_ID;
   assign m_axi_awlen   = '0;
   assign m_axi_awsize  = axi_size(DATA_W);
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = CACHE_MODIFIABLE_BUF;
   assign m_axi_awprot  = '0;
   assign m_axi_awqos   = '0;

   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wlast   = 1'b1;

   assign m_axi_araddr  = addr_q;
   assign m_axi_arid    = AXI_ID;
   assign m_axi_arlen   = '0;
   assign m_axi_arsize  = axi_size(DATA_W);
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = CACHE_MODIFIABLE_BUF;
   assign m_axi_arprot  = '0;
   assign m_axi_arqos   = '0;

   always_ff @(posedge clk) begin
      if (uncore_reset) begin
         state         <= IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         wd_cnt        <= '0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         hang_o        <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         // Watchdog only observes; the transaction keeps waiting after it fires.
         if (busy) begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_MAX - WD_W'(1)) hang_o <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  addr_q    <= req_addr & ALIGN_MASK;
                  wdata_q   <= req_wdata;
                  wstrb_q   <= req_wstrb;
                  if (req_we) begin
                     state         <= WR;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                  end else begin
                     state         <= RD;
                     m_axi_arvalid <= 1'b1;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end

            WR: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
               if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                  state        <= WAIT_B;
                  m_axi_bready <= 1'b1;
               end
            end

            WAIT_B: begin
               if (m_axi_bvalid) begin
                  state        <= RESP;
                  m_axi_bready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_rdata    <= '0;
                  rsp_err      <= (m_axi_bresp != RESP_OKAY);
                  wd_cnt       <= '0;
               end
            end

            RD: begin
               if (m_axi_arready) begin
                  state         <= WAIT_R;
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
               end
            end

            WAIT_R: begin
               if (m_axi_rvalid) begin
                  state        <= RESP;
                  m_axi_rready <= 1'b0;
                  rsp_valid    <= 1'b1;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_err      <= (m_axi_rresp != RESP_OKAY) || !m_axi_rlast;
                  wd_cnt       <= '0;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hbm_axi_mem_bridge.sv
// Directed bench for hbm_axi_mem_bridge: the bench plays core and AXI slave.
module tb_hbm_axi_mem_bridge;

   logic         clk = 1'b0;
   logic         uncore_reset;
   logic         req_valid, req_ready, req_we;
   logic [32:0]  req_addr;
   logic [255:0] req_wdata;
   logic [31:0]  req_wstrb;
   logic         rsp_valid, rsp_ready, rsp_err, hang_o;
   logic [255:0] rsp_rdata;

   logic [32:0]  m_axi_awaddr, m_axi_araddr;
   logic [5:0]   m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [7:0]   m_axi_awlen, m_axi_arlen;
   logic [2:0]   m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
   logic [1:0]   m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic         m_axi_awlock, m_axi_arlock;
   logic [3:0]   m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
   logic         m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [255:0] m_axi_wdata, m_axi_rdata;
   logic [31:0]  m_axi_wstrb;
   logic         m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int checks = 0;
   int errors = 0;

   hbm_axi_mem_bridge #(
      .ADDR_W(33), .DATA_W(256), .ID_W(6), .AXI_ID(6'd5), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .uncore_reset(uncore_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .hang_o(hang_o),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
      .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
      .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_idle();
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = 6'd5;
      m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rdata = '0; m_axi_rid = 6'd5;
   endtask

   // Zero-wait slave: every channel ready/valid, responses only sampled when the bridge wants them.
   task automatic slave_all(input logic [1:0] resp, input logic last, input logic [255:0] rd);
      m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
      m_axi_bvalid = 1'b1; m_axi_bresp = resp;
      m_axi_rvalid = 1'b1; m_axi_rresp = resp; m_axi_rlast = last; m_axi_rdata = rd;
   endtask

   task automatic send_req(input logic we, input logic [32:0] addr, input logic [255:0] wd,
                           input logic [31:0] ws);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL %s_rsp_timeout got %b exp 1", tag, rsp_valid); end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      uncore_reset = 1'b1;
      tick(); tick();
      checks++; if ({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_err, hang_o} !== 9'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_err, hang_o}); end
      checks++; if (rsp_rdata !== 256'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
      uncore_reset = 1'b0;
      tick();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_write_zero_wait();
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      send_req(1'b1, 33'h1_0000_0040, {4{64'h0123_4567_89AB_CDEF}}, 32'hFFFF_FFFF);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL w1_req_ready got %b exp 0", req_ready); end
      checks++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b11) begin errors++; $display("FAIL w1_aw_w_valid got %b exp 11", {m_axi_awvalid, m_axi_wvalid}); end
      checks++; if (m_axi_awaddr !== 33'h1_0000_0040) begin errors++; $display("FAIL w1_awaddr got %h exp 100000040", m_axi_awaddr); end
      checks++; if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock} !== {8'd0, 3'd5, 2'b01, 1'b0}) begin errors++; $display("FAIL w1_len_size_burst_lock got %h %h %h %b exp 0 5 1 0", m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock); end
      checks++; if ({m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awid} !== {4'b0011, 3'd0, 4'd0, 6'd5}) begin errors++; $display("FAIL w1_cache_prot_qos_id got %h %h %h %h exp 3 0 0 5", m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awid); end
      checks++; if (m_axi_wlast !== 1'b1) begin errors++; $display("FAIL w1_wlast got %b exp 1", m_axi_wlast); end
      checks++; if ({m_axi_wdata, m_axi_wstrb} !== {{4{64'h0123_4567_89AB_CDEF}}, 32'hFFFF_FFFF}) begin errors++; $display("FAIL w1_wpayload got %h %h", m_axi_wdata, m_axi_wstrb); end
      checks++; if (m_axi_bready !== 1'b0) begin errors++; $display("FAIL w1_bready_early got %b exp 0", m_axi_bready); end
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      tick();
      checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid} !== 4'b0010) begin errors++; $display("FAIL w1_wait_b got %b exp 0010", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, rsp_valid}); end
      tick();
      m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      checks++; if ({rsp_valid, rsp_err, m_axi_bready} !== 3'b100) begin errors++; $display("FAIL w1_rsp_t3 got %b exp 100", {rsp_valid, rsp_err, m_axi_bready}); end
      checks++; if (rsp_rdata !== 256'd0) begin errors++; $display("FAIL w1_rdata got %h exp 0", rsp_rdata); end
      consume();
      checks++; if ({rsp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL w1_back_idle got %b exp 01", {rsp_valid, req_ready}); end
   endtask

   task automatic test_write_aw_delay();
      int aw_cycles = 0;
      int w_cycles = 0;
      int b_hs = 0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b1;
      send_req(1'b1, 33'h0_1234_5678, {8{32'h5555_AAAA}}, 32'h0000_FFFF);
      checks++; if (m_axi_awaddr !== 33'h0_1234_5660) begin errors++; $display("FAIL w2_awaddr_align got %h exp 012345660", m_axi_awaddr); end
      for (int c = 0; c < 4; c++) begin
         if (m_axi_awvalid === 1'b1) aw_cycles++;
         if (m_axi_wvalid === 1'b1) w_cycles++;
         if (c == 3) m_axi_awready = 1'b1;
         tick();
         if (c == 0) m_axi_wready = 1'b0;
      end
      m_axi_awready = 1'b0;
      checks++; if (aw_cycles != 4) begin errors++; $display("FAIL w2_awvalid_cycles got %0d exp 4", aw_cycles); end
      checks++; if (w_cycles != 1) begin errors++; $display("FAIL w2_wvalid_cycles got %0d exp 1", w_cycles); end
      checks++; if ({m_axi_awvalid, m_axi_bready} !== 2'b01) begin errors++; $display("FAIL w2_wait_b got %b exp 01", {m_axi_awvalid, m_axi_bready}); end
      m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
      for (int c = 0; c < 3; c++) begin
         if (m_axi_bvalid === 1'b1 && m_axi_bready === 1'b1) b_hs++;
         tick();
      end
      m_axi_bvalid = 1'b0;
      checks++; if (b_hs != 1) begin errors++; $display("FAIL w2_b_handshakes got %0d exp 1", b_hs); end
      checks++; if ({rsp_valid, rsp_err, hang_o} !== 3'b100) begin errors++; $display("FAIL w2_rsp got %b exp 100", {rsp_valid, rsp_err, hang_o}); end
      consume();
   endtask

   task automatic test_read_ok();
      m_axi_arready = 1'b1;
      send_req(1'b0, 33'h0_0000_0020, '0, '0);
      checks++; if ({m_axi_arvalid, m_axi_rready, m_axi_awvalid} !== 3'b100) begin errors++; $display("FAIL r1_rd_state got %b exp 100", {m_axi_arvalid, m_axi_rready, m_axi_awvalid}); end
      checks++; if (m_axi_araddr !== 33'h0_0000_0020) begin errors++; $display("FAIL r1_araddr got %h exp 000000020", m_axi_araddr); end
      checks++; if ({m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid} !== {8'd0, 3'd5, 2'b01, 4'b0011, 6'd5}) begin errors++; $display("FAIL r1_ar_fields got %h %h %h %h %h exp 0 5 1 3 5", m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid); end
      m_axi_rvalid = 1'b1; m_axi_rdata = {32{8'hA5}}; m_axi_rresp = 2'b00; m_axi_rlast = 1'b1;
      tick();
      checks++; if ({m_axi_arvalid, m_axi_rready} !== 2'b01) begin errors++; $display("FAIL r1_wait_r got %b exp 01", {m_axi_arvalid, m_axi_rready}); end
      tick();
      slave_idle();
      checks++; if ({rsp_valid, rsp_err, m_axi_rready} !== 3'b100) begin errors++; $display("FAIL r1_rsp got %b exp 100", {rsp_valid, rsp_err, m_axi_rready}); end
      checks++; if (rsp_rdata !== {32{8'hA5}}) begin errors++; $display("FAIL r1_rdata got %h exp a5..a5", rsp_rdata); end
      consume();
   endtask

   task automatic test_errors();
      slave_all(2'b10, 1'b1, {8{32'h1111_2222}});
      send_req(1'b0, 33'h0_0000_1000, '0, '0);
      wait_rsp("e1");
      checks++; if ({rsp_err, rsp_rdata} !== {1'b1, {8{32'h1111_2222}}}) begin errors++; $display("FAIL e1_slverr got %b %h exp 1 11112222..", rsp_err, rsp_rdata); end
      consume();
      slave_all(2'b11, 1'b1, '0);
      send_req(1'b1, 33'h0_0000_2000, {8{32'h3333_4444}}, 32'hFFFF_FFFF);
      wait_rsp("e2");
      checks++; if ({rsp_err, rsp_rdata} !== {1'b1, 256'd0}) begin errors++; $display("FAIL e2_decerr got %b %h exp 1 0", rsp_err, rsp_rdata); end
      consume();
      slave_all(2'b00, 1'b0, {8{32'h7777_8888}});
      send_req(1'b0, 33'h0_0000_3000, '0, '0);
      wait_rsp("e3");
      checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL e3_no_rlast got %b exp 1", rsp_err); end
      consume();
      slave_all(2'b00, 1'b1, '0);
      send_req(1'b1, 33'h0_0000_403F, {8{32'h9999_0000}}, 32'h0);
      checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_wstrb, m_axi_awaddr} !== {2'b11, 32'h0, 33'h0_0000_4020}) begin errors++; $display("FAIL e4_zero_strb got %b %b %h %h exp 1 1 0 000004020", m_axi_awvalid, m_axi_wvalid, m_axi_wstrb, m_axi_awaddr); end
      wait_rsp("e4");
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL e4_err got %b exp 0", rsp_err); end
      consume();
      slave_idle();
   endtask

   task automatic test_back_to_back();
      int rr_bad = 0;
      int rv_bad = 0;
      int ar_bad = 0;
      slave_all(2'b00, 1'b1, {8{32'hCAFE_F00D}});
      send_req(1'b0, 33'h0_0000_0040, '0, '0);
      wait_rsp("b1");
      m_axi_rdata = {8{32'h0BAD_F00D}};
      req_valid = 1'b1; req_we = 1'b0; req_addr = 33'h0_0000_0080;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (req_ready !== 1'b0) rr_bad++;
         if (rsp_valid !== 1'b1) rv_bad++;
         if (m_axi_arvalid !== 1'b0) ar_bad++;
      end
      checks++; if (rr_bad != 0) begin errors++; $display("FAIL b1_req_ready_hold got %0d bad cycles exp 0", rr_bad); end
      checks++; if (rv_bad != 0) begin errors++; $display("FAIL b1_rsp_valid_hold got %0d bad cycles exp 0", rv_bad); end
      checks++; if (ar_bad != 0) begin errors++; $display("FAIL b1_no_early_ar got %0d bad cycles exp 0", ar_bad); end
      checks++; if (rsp_rdata !== {8{32'hCAFE_F00D}}) begin errors++; $display("FAIL b1_rdata_stable got %h exp cafef00d..", rsp_rdata); end
      consume();
      checks++; if ({rsp_valid, req_ready, m_axi_arvalid} !== 3'b010) begin errors++; $display("FAIL b1_after_rsp got %b exp 010", {rsp_valid, req_ready, m_axi_arvalid}); end
      tick();
      req_valid = 1'b0;
      checks++; if ({m_axi_arvalid, req_ready, m_axi_araddr} !== {2'b10, 33'h0_0000_0080}) begin errors++; $display("FAIL b1_second_accept got %b %b %h exp 1 0 000000080", m_axi_arvalid, req_ready, m_axi_araddr); end
      wait_rsp("b2");
      checks++; if (rsp_rdata !== {8{32'h0BAD_F00D}}) begin errors++; $display("FAIL b2_rdata got %h exp 0badf00d..", rsp_rdata); end
      consume();
      slave_idle();
   endtask

   task automatic test_watchdog();
      int early = 0;
      int late_bad = 0;
      slave_idle();
      send_req(1'b0, 33'h0_0000_0100, '0, '0);
      for (int c = 0; c < 15; c++) begin
         tick();
         if (hang_o !== 1'b0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL h1_hang_early got %0d cycles exp 0", early); end
      tick();
      checks++; if ({hang_o, m_axi_arvalid} !== 2'b11) begin errors++; $display("FAIL h1_hang_at_16 got %b exp 11", {hang_o, m_axi_arvalid}); end
      for (int c = 0; c < 5; c++) begin
         tick();
         if ({hang_o, m_axi_arvalid} !== 2'b11) late_bad++;
      end
      checks++; if (late_bad != 0) begin errors++; $display("FAIL h1_hang_sticky got %0d bad cycles exp 0", late_bad); end
      uncore_reset = 1'b1;
      tick();
      checks++; if ({req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_err, hang_o} !== 9'b0) begin errors++; $display("FAIL h1_reset_ctrl got %b exp 0", {req_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, rsp_err, hang_o}); end
      checks++; if (rsp_rdata !== 256'd0) begin errors++; $display("FAIL h1_reset_rdata got %h exp 0", rsp_rdata); end
      uncore_reset = 1'b0;
      tick();
      checks++; if ({req_ready, hang_o} !== 2'b10) begin errors++; $display("FAIL h1_post_reset got %b exp 10", {req_ready, hang_o}); end
      slave_all(2'b00, 1'b1, {8{32'h1234_5678}});
      send_req(1'b0, 33'h0_0000_0200, '0, '0);
      wait_rsp("h2");
      checks++; if ({rsp_err, rsp_rdata} !== {1'b0, {8{32'h1234_5678}}}) begin errors++; $display("FAIL h2_read_after_reset got %b %h exp 0 12345678..", rsp_err, rsp_rdata); end
      consume();
      slave_idle();
   endtask

   initial begin
      uncore_reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      rsp_ready = 1'b0;
      slave_idle();
      test_reset();
      test_write_zero_wait();
      test_write_aw_delay();
      test_read_ok();
      test_errors();
      test_back_to_back();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got stuck exp finish");
      $fatal(1, "bench time limit");
   end

endmodule
